// File: rtl/alu_result_fifo.sv
// Capture FIFO for ALU results pushed and popped by synchronised, rising-edge-detected pin strobes.
// Latency: a pin rise becomes a one-cycle event SYNC_STAGES clocks later; the head is visible one clock after the event.
// Backpressure: none. A push while full is dropped and sets ovf; a pop while empty is ignored and sets udf (both sticky).
//
// Ports: clk, rst_n (async, active low), ena (gates strobe events), res_in/carry_in/zero_in (ALU sample),
//        push_pin/pop_pin (async strobes), dout/carry_out/zero_out (show-ahead head entry),
//        empty/full/count (occupancy), ovf/udf (sticky errors), stat_cnt (carry-push counter).
// Build option: define ALU_FIFO_STATS_EN to build the saturating carry-push counter; otherwise stat_cnt is 0.
module alu_result_fifo #(
    parameter int DEPTH       = 4,
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic [DW-1:0]              res_in,
    input  logic                       carry_in,
    input  logic                       zero_in,
    input  logic                       push_pin,
    input  logic                       pop_pin,
    output logic [DW-1:0]              dout,
    output logic                       carry_out,
    output logic                       zero_out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    output logic                       udf,
    output logic [7:0]                 stat_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DW + 2;

    // Strobe synchronisers plus one history flop each for edge detection
    logic [SYNC_STAGES-1:0] push_sync, pop_sync;
    logic                   push_hist, pop_hist;
    logic                   push_ev, pop_ev;

    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]  count_q, count_nxt;
    logic           empty_q, full_q;
    logic [EW-1:0]  head_q;
    logic [EW-1:0]  wr_dat;
    logic           do_push, do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_sync <= '0;
            pop_sync  <= '0;
            push_hist <= 1'b0;
            pop_hist  <= 1'b0;
        end else begin
            push_sync <= {push_sync[SYNC_STAGES-2:0], push_pin};
            pop_sync  <= {pop_sync[SYNC_STAGES-2:0], pop_pin};
            push_hist <= push_sync[SYNC_STAGES-1];
            pop_hist  <= pop_sync[SYNC_STAGES-1];
        end
    end

    // Synchronisers keep running while ena is low so no stale edge appears when it returns
    assign push_ev = ena & push_sync[SYNC_STAGES-1] & ~push_hist;
    assign pop_ev  = ena & pop_sync[SYNC_STAGES-1]  & ~pop_hist;

    // A push into a full FIFO still succeeds when a pop frees the head in the same cycle;
    // a pop into an empty FIFO never succeeds, even alongside a push.
    assign do_push = push_ev & (~full_q | pop_ev);
    assign do_pop  = pop_ev & ~empty_q;
    assign wr_dat  = {res_in, carry_in, zero_in};

    always_comb begin
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count_q;
        if (do_pop) rd_ptr_nxt = rd_ptr + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            head_q  <= '0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == CW'(DEPTH));
            // Show-ahead head: bypass the write data when it lands at the new head slot,
            // because the array does not hold it until after this edge. Hold when going empty.
            if (count_nxt != '0) begin
                if (do_push && (wr_ptr == rd_ptr_nxt)) head_q <= wr_dat;
                else                                   head_q <= mem[rd_ptr_nxt];
            end
            if (push_ev && full_q && !pop_ev) ovf <= 1'b1;
            if (pop_ev && empty_q)            udf <= 1'b1;
        end
    end

`ifdef ALU_FIFO_STATS_EN
    logic [7:0] stat_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        stat_q <= 8'h00;
        else if (do_push && carry_in && stat_q != 8'hFF)   stat_q <= stat_q + 8'd1;
    end
    assign stat_cnt = stat_q;
`else
    assign stat_cnt = 8'h00;
`endif

    assign dout      = head_q[EW-1:2];
    assign carry_out = head_q[1];
    assign zero_out  = head_q[0];
    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo with a queue scoreboard of expected FIFO contents.
// Latency: stimulus changes on the falling edge; outputs are sampled on the falling edge.
// Backpressure: modelled in the scoreboard (drop when full, ignore pop when empty).
module tb_alu_result_fifo;
    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int SS    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [DW-1:0] res_in;
    logic          carry_in, zero_in;
    logic          push_pin, pop_pin;
    logic [DW-1:0] dout;
    logic          carry_out, zero_out, empty, full, ovf, udf;
    logic [2:0]    count;
    logic [7:0]    stat_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW+1:0] sb_q[$];
    logic          ovf_exp, udf_exp;
    int            stat_exp;

    alu_result_fifo #(.DEPTH(DEPTH), .DW(DW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .res_in(res_in), .carry_in(carry_in), .zero_in(zero_in),
        .push_pin(push_pin), .pop_pin(pop_pin),
        .dout(dout), .carry_out(carry_out), .zero_out(zero_out),
        .empty(empty), .full(full), .count(count),
        .ovf(ovf), .udf(udf), .stat_cnt(stat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"}, 32'(count), 32'(sb_q.size()));
        check({tag, ".empty"}, 32'(empty), 32'(sb_q.size() == 0));
        check({tag, ".full"},  32'(full),  32'(sb_q.size() == DEPTH));
        check({tag, ".ovf"},   32'(ovf),   32'(ovf_exp));
        check({tag, ".udf"},   32'(udf),   32'(udf_exp));
        check({tag, ".stat"},  32'(stat_cnt), 32'(stat_exp));
        if (sb_q.size() != 0)
            check({tag, ".head"}, 32'({dout, carry_out, zero_out}), 32'(sb_q[0]));
    endtask

    task automatic model_reset();
        sb_q.delete();
        ovf_exp  = 1'b0;
        udf_exp  = 1'b0;
        stat_exp = 0;
    endtask

    task automatic model_push(input logic [DW+1:0] e);
        sb_q.push_back(e);
`ifdef ALU_FIFO_STATS_EN
        if (e[1] && stat_exp < 255) stat_exp++;
`endif
    endtask

    // Drive pins high together for `hi` cycles with stable data, then let them settle low.
    task automatic strobe(input bit do_push, input bit do_pop, input logic [DW-1:0] d,
                          input logic c, input logic z, input int hi);
        logic [DW+1:0] e;
        e = {d, c, z};
        @(negedge clk);
        res_in = d; carry_in = c; zero_in = z;
        push_pin = do_push; pop_pin = do_pop;
        if (ena) begin
            if (do_push && do_pop) begin
                if (sb_q.size() == 0) begin
                    model_push(e);
                    udf_exp = 1'b1;
                end else begin
                    void'(sb_q.pop_front());
                    model_push(e);
                end
            end else if (do_push) begin
                if (sb_q.size() == DEPTH) ovf_exp = 1'b1;
                else                      model_push(e);
            end else if (do_pop) begin
                if (sb_q.size() == 0) udf_exp = 1'b1;
                else                  void'(sb_q.pop_front());
            end
        end
        repeat (hi) @(negedge clk);
        push_pin = 1'b0; pop_pin = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; res_in = '0; carry_in = 1'b0; zero_in = 1'b0;
        push_pin = 1'b0; pop_pin = 1'b0;
        model_reset();
        #12;
        check_status("reset");
        check("reset.dout", 32'({dout, carry_out, zero_out}), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single push, latency boundary then value
        res_in = 8'h3C; carry_in = 1'b1; zero_in = 1'b0;
        push_pin = 1'b1;
        repeat (SS) @(negedge clk);
        check("t1.not_yet", 32'(count), 32'd0);
        repeat (2) @(negedge clk);
        model_push({8'h3C, 1'b1, 1'b0});
        check("t1.count", 32'(count), 32'd1);
        check("t1.dout",  32'(dout), 32'h3C);
        check("t1.carry", 32'(carry_out), 32'd1);
        check("t1.zero",  32'(zero_out), 32'd0);
        push_pin = 1'b0;
        repeat (6) @(negedge clk);
        check_status("t1");
        strobe(0, 1, 8'h00, 0, 0, 2);
        check_status("t1.pop");

        // 2: fill, overflow, drain in order
        for (int i = 1; i <= 5; i++) begin
            strobe(1, 0, 8'(i), 1'(i % 2), 1'(i == 3), 2);
            check_status("t2.push");
        end
        for (int i = 1; i <= 4; i++) begin
            check("t2.order", 32'(dout), 32'(i));
            strobe(0, 1, 8'h00, 0, 0, 2);
            check_status("t2.pop");
        end

        // 3: underflow, then simultaneous push/pop into empty
        strobe(0, 1, 8'h00, 0, 0, 3);
        check_status("t3.udf");
        strobe(1, 1, 8'h5A, 0, 1, 3);
        check_status("t3.both_empty");
        strobe(0, 1, 8'h00, 0, 0, 2);

        // 4: full + simultaneous push/pop, pointer wrap
        for (int i = 0; i < 4; i++) strobe(1, 0, 8'h10 + 8'(i), 0, 0, 2);
        check_status("t4.full");
        strobe(1, 1, 8'hAA, 1, 0, 2);
        check_status("t4.both_full");
        for (int i = 0; i < 4; i++) begin
            check_status("t4.drain");
            strobe(0, 1, 8'h00, 0, 0, 2);
        end
        check_status("t4.empty");

        // 5: ena gating and held-high pin
        ena = 1'b0;
        for (int i = 0; i < 3; i++) strobe(1, 0, 8'hEE, 1, 1, 2);
        ena = 1'b1;
        check_status("t5.gated");
        strobe(1, 0, 8'h77, 0, 1, 20);
        check_status("t5.held");

        // 6: many carry pushes paired with pops (saturates the counter when built)
        for (int i = 0; i < 300; i++) strobe(1, 1, 8'(i), 1, 0, 1);
        check_status("t6.stats");

        // 6b: async reset mid-operation, observed without a clock edge
        strobe(1, 0, 8'h99, 1, 1, 2);
        @(negedge clk);
        push_pin = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_status("t6.rst");
        check("t6.rst.dout", 32'({dout, carry_out, zero_out}), 32'h0);
        @(negedge clk);
        push_pin = 1'b0;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_status("t6.after_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
